// File: rtl/screen_scanner_if.sv
// Word-read bus between the screen scanner (master) and the screen region of data memory (slave).
// rd_data is valid exactly one clock after rd_en.
interface screen_scanner_if #(
  parameter int ADDR_W = 13
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/screen_scanner.sv
// Raster scan engine: walks the screen map, fetches one word per 16 pixels and serializes it
// LSB-first. pixel/de/hsync/vsync lag the counters by 2 clks; rd_en/rd_addr/frame_done by 1 clk.
module screen_scanner #(
  parameter int H_ACTIVE = 512,
  parameter int H_BLANK  = 32,
  parameter int H_SYNC   = 16,
  parameter int V_ACTIVE = 256,
  parameter int V_BLANK  = 8,
  parameter int V_SYNC   = 2,
  parameter int ADDR_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  screen_scanner_if.master bus,
  output logic             pixel,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_done
);

  localparam int H_TOTAL        = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL        = V_ACTIVE + V_BLANK;
  localparam int HW             = $clog2(H_TOTAL);
  localparam int VW             = $clog2(V_TOTAL);
  localparam int WORDS_PER_LINE = H_ACTIVE / 16;

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_L = HW'(H_SYNC);
  localparam logic [HW-1:0] H_MAX_L  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_L = VW'(V_SYNC);
  localparam logic [VW-1:0] V_MAX_L  = VW'(V_TOTAL - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t            r_state;
  logic [HW-1:0]     r_h_cnt;
  logic [VW-1:0]     r_v_cnt;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_load;
  logic [15:0]       r_shift;
  logic              r_de_s1, r_hs_s1, r_vs_s1;
  logic              r_de, r_hs, r_vs;
  logic              r_frame_done;

  logic              w_scan, w_h_act, w_v_act, w_h_max, w_v_max;
  logic              w_hs, w_vs, w_fetch;
  logic [ADDR_W-1:0] w_addr;

  assign w_scan  = (r_state == SCAN);
  assign w_h_act = (r_h_cnt < H_ACT_L);
  assign w_v_act = (r_v_cnt < V_ACT_L);
  assign w_h_max = (r_h_cnt == H_MAX_L);
  assign w_v_max = (r_v_cnt == V_MAX_L);
  // Offset-from-start compares stay correct even when the sync end equals the counter range.
  assign w_hs    = !w_h_act && ((r_h_cnt - H_ACT_L) < H_SYNC_L);
  assign w_vs    = !w_v_act && ((r_v_cnt - V_ACT_L) < V_SYNC_L);
  assign w_fetch = w_scan && w_h_act && w_v_act && (r_h_cnt[3:0] == 4'd0);
  assign w_addr  = ADDR_W'(r_v_cnt) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(r_h_cnt >> 4);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_load       <= 1'b0;
      r_shift      <= '0;
      r_de_s1      <= 1'b0;
      r_hs_s1      <= 1'b0;
      r_vs_s1      <= 1'b0;
      r_de         <= 1'b0;
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en <= w_fetch;
      if (w_fetch) begin
        r_rd_addr <= w_addr;
      end
      r_load  <= r_rd_en;
      r_shift <= r_load ? {1'b0, bus.rd_data[15:1]} : {1'b0, r_shift[15:1]};

      r_de_s1      <= w_scan && w_h_act && w_v_act;
      r_hs_s1      <= w_scan && w_hs;
      r_vs_s1      <= w_scan && w_vs;
      r_de         <= r_de_s1;
      r_hs         <= r_hs_s1;
      r_vs         <= r_vs_s1;
      r_frame_done <= w_scan && w_h_max && w_v_max;

      case (r_state)
        IDLE: begin
          r_h_cnt <= '0;
          r_v_cnt <= '0;
          if (enable) begin
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_h_max) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_max ? '0 : r_v_cnt + VW'(1);
            if (w_v_max && !enable) begin
              r_state <= IDLE;
            end
          end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
          end
        end
      endcase
    end
  end

  // The returned word's first pixel is tapped straight from rd_data so no clock is lost on load.
  assign pixel       = r_load ? bus.rd_data[0] : r_shift[0];
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign frame_done  = r_frame_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;

endmodule

// File: tb/tb_screen_scanner.sv
// Self-checking bench for screen_scanner on a reduced raster (32+8 x 4+3, 8 screen words).
// A frame-position model predicts every output each cycle; literal checks pin the model.
module tb_screen_scanner;

  localparam int HA = 32, HB = 8, HS = 3, VA = 4, VB = 3, VS = 2, AW = 3;
  localparam int HT = HA + HB, VT = VA + VB, FRAME = HT * VT;
  localparam int WORDS = HA / 16, NWORDS = 1 << AW;

  typedef struct packed {
    bit scan;
    int t;
  } pos_t;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;
  logic pixel, de, hsync, vsync, frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0]   mem [NWORDS];
  pos_t          cur      = '0;
  pos_t          p1       = '0;
  pos_t          p2       = '0;
  logic [AW-1:0] exp_addr = '0;

  screen_scanner_if #(.ADDR_W(AW)) bus ();

  screen_scanner #(
    .H_ACTIVE(HA), .H_BLANK(HB), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_BLANK(VB), .V_SYNC(VS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Memory: data one clock after the strobe, noise otherwise.
  always @(posedge clk) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : 16'($urandom);

  function automatic int h_of(pos_t p); return p.t % HT; endfunction
  function automatic int v_of(pos_t p); return p.t / HT; endfunction
  function automatic bit in_active(pos_t p);
    return p.scan && h_of(p) < HA && v_of(p) < VA;
  endfunction
  function automatic int word_of(pos_t p);
    return (v_of(p) * WORDS + h_of(p) / 16) % NWORDS;
  endfunction
  function automatic bit fetch(pos_t p);
    return in_active(p) && (h_of(p) % 16 == 0);
  endfunction
  function automatic bit exp_px(pos_t p);
    if (!in_active(p)) return 1'b0;
    return mem[AW'(word_of(p))][4'(h_of(p) % 16)];
  endfunction
  function automatic bit exp_hs(pos_t p);
    return p.scan && h_of(p) >= HA && h_of(p) < HA + HS;
  endfunction
  function automatic bit exp_vs(pos_t p);
    return p.scan && v_of(p) >= VA && v_of(p) < VA + VS;
  endfunction
  function automatic bit exp_fd(pos_t p);
    return p.scan && p.t == FRAME - 1;
  endfunction
  function automatic pos_t next_pos(pos_t p, logic en);
    pos_t n = p;
    if (!p.scan) begin
      if (en) begin
        n.scan = 1'b1;
        n.t    = 0;
      end
    end else if (p.t == FRAME - 1) begin
      n.t    = 0;
      n.scan = en;
    end else begin
      n.t = p.t + 1;
    end
    return n;
  endfunction

  // cur = frame position during this cycle; p1/p2 = one and two cycles earlier.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= '0;
      p1       <= '0;
      p2       <= '0;
      exp_addr <= '0;
    end else begin
      p2       <= p1;
      p1       <= cur;
      exp_addr <= fetch(cur) ? AW'(word_of(cur)) : exp_addr;
      cur      <= next_pos(cur, enable);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge clk) begin
    check("rd_en",      32'(bus.rd_en),   32'(fetch(p1)));
    check("rd_addr",    32'(bus.rd_addr), 32'(exp_addr));
    check("frame_done", 32'(frame_done),  32'(exp_fd(p1)));
    check("de",         32'(de),          32'(in_active(p2)));
    check("hsync",      32'(hsync),       32'(exp_hs(p2)));
    check("vsync",      32'(vsync),       32'(exp_vs(p2)));
    check("pixel",      32'(pixel),       32'(exp_px(p2)));
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_rd(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.rd_en) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   32'(bus.rd_en),   32'd0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    check({tag, "_pixel"},   32'(pixel),       32'd0);
    check({tag, "_de"},      32'(de),          32'd0);
    check({tag, "_hsync"},   32'(hsync),       32'd0);
    check({tag, "_vsync"},   32'(vsync),       32'd0);
    check({tag, "_fdone"},   32'(frame_done),  32'd0);
  endtask

  initial begin
    int first_rd = -1, first_addr = -1, second_rd = -1, second_addr = -1;
    int n_rd = 0, line1_en = 0, line1_addr = -1;
    int first_de = -1, de_line0 = 0, hs_first = -1, hs_line0 = 0;
    int vs_first = -1, vs_cnt = 0, fd_k = -1, fd_cnt = 0;
    int a7_k = -1, after7_k = -1, after7_addr = -1;
    int rd_before = 0, rd_after = 0, lat;
    logic [31:0] px_mask = '0;

    for (int i = 0; i < NWORDS; i++) mem[AW'(i)] = 16'($urandom);
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;

    // Reset held with enable high.
    rst    = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    cyc = 0;

    // First frame: read cadence, pixel order, sync placement, frame timing.
    for (int k = 1; k <= FRAME + 5; k++) begin
      step();
      if (bus.rd_en) begin
        if (first_rd < 0) begin
          first_rd   = cyc;
          first_addr = int'(bus.rd_addr);
        end else if (second_rd < 0) begin
          second_rd   = cyc;
          second_addr = int'(bus.rd_addr);
        end
        if (cyc <= FRAME + 1) n_rd++;
        if (a7_k < 0 && int'(bus.rd_addr) == 7) a7_k = cyc;
        else if (a7_k >= 0 && after7_k < 0) begin
          after7_k    = cyc;
          after7_addr = int'(bus.rd_addr);
        end
      end
      if (cyc == 42) begin
        line1_en   = int'(bus.rd_en);
        line1_addr = int'(bus.rd_addr);
      end
      if (de && first_de < 0) first_de = cyc;
      if (cyc >= 3 && cyc < 3 + HT) begin
        if (de) de_line0++;
        if (hsync) hs_line0++;
        if (pixel && cyc < 3 + HA) px_mask[5'(cyc - 3)] = 1'b1;
      end
      if (hsync && hs_first < 0) hs_first = cyc;
      if (vsync) begin
        if (vs_first < 0) vs_first = cyc;
        vs_cnt++;
      end
      if (frame_done) begin
        fd_cnt++;
        if (fd_k < 0) fd_k = cyc;
      end
    end
    check("first_rd_cycle",  32'(first_rd),           32'd2);
    check("first_rd_addr",   32'(first_addr),         32'd0);
    check("second_rd_gap",   32'(second_rd - first_rd), 32'd16);
    check("second_rd_addr",  32'(second_addr),        32'd1);
    check("line1_rd_en",     32'(line1_en),           32'd1);
    check("line1_rd_addr",   32'(line1_addr),         32'd2);
    check("reads_per_frame", 32'(n_rd),               32'd8);
    check("first_de_cycle",  32'(first_de),           32'd3);
    check("de_per_line",     32'(de_line0),           32'd32);
    check("line0_pixels",    px_mask,                 32'h8000_0001);
    check("hsync_start",     32'(hs_first),           32'd35);
    check("hsync_width",     32'(hs_line0),           32'd3);
    check("vsync_start",     32'(vs_first),           32'd163);
    check("vsync_clocks",    32'(vs_cnt),             32'd80);
    check("frame_done_cyc",  32'(fd_k),               32'd281);
    check("frame_done_cnt",  32'(fd_cnt),             32'd1);
    check("last_addr_cycle", 32'(a7_k),               32'd138);
    check("wrap_rd_cycle",   32'(after7_k),           32'd282);
    check("wrap_rd_addr",    32'(after7_addr),        32'd0);

    // Drop enable on line 2 of frame 2: frame completes, then idle.
    while (cyc < 375) step();
    enable = 1'b0;
    fd_k   = -1;
    fd_cnt = 0;
    while (cyc < 700) begin
      step();
      if (frame_done) begin
        fd_cnt++;
        if (fd_k < 0) fd_k = cyc;
      end
      if (bus.rd_en) begin
        if (fd_k < 0) rd_before++;
        else rd_after++;
      end
    end
    check("drop_fd_cycle",  32'(fd_k),      32'd561);
    check("drop_fd_count",  32'(fd_cnt),    32'd1);
    check("drop_rd_before", 32'(rd_before), 32'd3);
    check("idle_rd_count",  32'(rd_after),  32'd0);
    enable = 1'b1;
    wait_rd(lat);
    check("resume_rd_lat",  32'(lat),            32'd2);
    check("resume_rd_addr", 32'(bus.rd_addr),    32'd0);

    // Asynchronous reset mid-line.
    repeat (150) step();
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("midrst");
    for (int i = 0; i < NWORDS; i++) mem[AW'(i)] = 16'($urandom);
    repeat (3) step();
    rst = 1'b1;
    wait_rd(lat);
    check("rst_restart_lat",  32'(lat),         32'd2);
    check("rst_restart_addr", 32'(bus.rd_addr), 32'd0);

    // Random enable pattern with occasional asynchronous resets.
    for (int s = 0; s < 25; s++) begin
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(20, 700)) step();
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #3 rst = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b1;
      end
    end
    enable = 1'b0;
    repeat (FRAME + 5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
